// File: rtl/trig_pkg.sv
// Shared constants, FSM state type and small helpers for the sequential sine controller.
package trig_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_REDUCE,
      S_ERR,
      S_RAD,
      S_X2,
      S_T3,
      S_T5,
      S_T7,
      S_T9,
      S_FINAL
   } state_t;

   localparam int unsigned SCALE       = 10000;
   localparam int unsigned RAD_NUM     = 220000;
   localparam int unsigned RAD_DEN     = 1260;
   localparam int unsigned DIV_T3      = 60000;
   localparam int unsigned DIV_T5      = 200000;
   localparam int unsigned DIV_T7      = 420000;
   localparam int unsigned DIV_T9      = 720000;
   localparam int unsigned DIV_CYCLES  = 32;
   localparam int unsigned ANGLE_LIMIT = 360;

   function automatic logic is_div_state(input state_t s);
      return (s == S_RAD) || (s == S_X2) || (s == S_T3) ||
             (s == S_T5)  || (s == S_T7) || (s == S_T9);
   endfunction

   // Constant divisor used by each division state.
   function automatic logic [31:0] state_divisor(input state_t s);
      case (s)
         S_RAD:   return RAD_DEN;
         S_X2:    return SCALE;
         S_T3:    return DIV_T3;
         S_T5:    return DIV_T5;
         S_T7:    return DIV_T7;
         S_T9:    return DIV_T9;
         default: return 32'd1;
      endcase
   endfunction

endpackage

// File: rtl/trig_div32.sv
// Restoring unsigned 32/32 divider: operands taken on go, quotient valid when rdy pulses
// after exactly DIV_CYCLES iterations (the first iteration happens on the go edge).
module trig_div32
   import trig_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic        rdy
);

   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_dvs;
   logic [5:0]  r_cnt;
   logic        r_active;
   logic        r_rdy;

   logic [31:0] w_rem_in;
   logic [31:0] w_quo_in;
   logic [31:0] w_dvs;
   logic [32:0] w_shift;
   logic [32:0] w_diff;
   logic        w_ge;
   logic [31:0] w_rem_next;
   logic [31:0] w_quo_next;

   // On go the step runs directly on the new operands, so no load-only cycle exists.
   always_comb begin
      w_rem_in   = go ? 32'd0    : r_rem;
      w_quo_in   = go ? dividend : r_quo;
      w_dvs      = go ? divisor  : r_dvs;
      w_shift    = {w_rem_in, w_quo_in[31]};
      w_diff     = w_shift - {1'b0, w_dvs};
      w_ge       = (w_shift >= {1'b0, w_dvs});
      w_rem_next = w_ge ? w_diff[31:0] : w_shift[31:0];
      w_quo_next = {w_quo_in[30:0], w_ge};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_rdy    <= 1'b0;
      end else if (go) begin
         r_rem    <= w_rem_next;
         r_quo    <= w_quo_next;
         r_dvs    <= divisor;
         r_cnt    <= 6'(DIV_CYCLES - 1);
         r_active <= 1'b1;
         r_rdy    <= 1'b0;
      end else if (r_active) begin
         r_rem <= w_rem_next;
         r_quo <= w_quo_next;
         r_cnt <= r_cnt - 6'd1;
         if (r_cnt == 6'd1) begin
            r_active <= 1'b0;
            r_rdy    <= 1'b1;
         end else begin
            r_rdy <= 1'b0;
         end
      end else begin
         r_rdy <= 1'b0;
      end
   end

   assign quotient = r_quo;
   assign rdy      = r_rdy;

endmodule

// File: rtl/sin_seq_ctrl.sv
// Sequential sine (optionally cosine via TRIG_COS_EN) of an integer angle in degrees,
// result x10000, evaluated with a 5-term Taylor series on one shared iterative divider.
module sin_seq_ctrl
   import trig_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [15:0]        angle,
`ifdef TRIG_COS_EN
   input  logic               func_sel,
`endif
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic signed [15:0] result
);

   state_t r_state;
   state_t w_state_next;

   logic [15:0]        r_angle;
`ifdef TRIG_COS_EN
   logic               r_func;
`endif
   logic [8:0]         r_d;
   logic               r_neg;
   logic [31:0]        r_x;
   logic [31:0]        r_x2;
   logic [31:0]        r_t;
   logic signed [17:0] r_acc;
   logic               r_go;
   logic               r_busy;
   logic               r_done;
   logic               r_err;
   logic signed [15:0] r_result;

   logic               w_angle_bad;
   logic [16:0]        w_a;
   logic [8:0]         w_d;
   logic               w_neg;
   logic [31:0]        w_dividend;
   logic [31:0]        w_divisor;
   logic [31:0]        w_quotient;
   logic               w_rdy;
   logic signed [17:0] w_q18;
   logic signed [17:0] w_mag;

   assign w_angle_bad = (r_angle >= 16'(ANGLE_LIMIT));

   // Optional cosine shift, then fold into the first quadrant.
   always_comb begin
`ifdef TRIG_COS_EN
      w_a = {1'b0, r_angle};
      if (r_func) begin
         w_a = {1'b0, r_angle} + 17'd90;
         if (w_a >= 17'(ANGLE_LIMIT)) w_a = w_a - 17'(ANGLE_LIMIT);
      end
`else
      w_a = {1'b0, r_angle};
`endif
      if (w_a <= 17'd90) begin
         w_d   = 9'(w_a);
         w_neg = 1'b0;
      end else if (w_a <= 17'd180) begin
         w_d   = 9'(17'd180 - w_a);
         w_neg = 1'b0;
      end else if (w_a <= 17'd270) begin
         w_d   = 9'(w_a - 17'd180);
         w_neg = 1'b1;
      end else begin
         w_d   = 9'(17'(ANGLE_LIMIT) - w_a);
         w_neg = 1'b1;
      end
   end

   always_comb begin
      w_dividend = '0;
      case (r_state)
         S_RAD:                  w_dividend = 32'(r_d) * RAD_NUM;
         S_X2:                   w_dividend = r_x * r_x;
         S_T3:                   w_dividend = r_x * r_x2;
         S_T5, S_T7, S_T9:       w_dividend = r_t * r_x2;
         default:                w_dividend = '0;
      endcase
      w_divisor = state_divisor(r_state);
   end

   trig_div32 u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .go       (r_go),
      .dividend (w_dividend),
      .divisor  (w_divisor),
      .quotient (w_quotient),
      .rdy      (w_rdy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_state_next = S_REDUCE;
         S_REDUCE: w_state_next = w_angle_bad ? S_ERR : S_RAD;
         S_ERR:    w_state_next = S_IDLE;
         S_RAD:    if (w_rdy) w_state_next = S_X2;
         S_X2:     if (w_rdy) w_state_next = S_T3;
         S_T3:     if (w_rdy) w_state_next = S_T5;
         S_T5:     if (w_rdy) w_state_next = S_T7;
         S_T7:     if (w_rdy) w_state_next = S_T9;
         S_T9:     if (w_rdy) w_state_next = S_FINAL;
         S_FINAL:  w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   assign w_q18 = $signed(w_quotient[17:0]);

   always_comb begin
      w_mag = r_acc;
      if (r_acc < 18'sd0)                   w_mag = 18'sd0;
      else if (r_acc > 18'sd10000)          w_mag = 18'(SCALE);
   end

   // Division issue pulse fires on the first cycle of each division state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_angle  <= '0;
`ifdef TRIG_COS_EN
         r_func   <= 1'b0;
`endif
         r_d      <= '0;
         r_neg    <= 1'b0;
         r_x      <= '0;
         r_x2     <= '0;
         r_t      <= '0;
         r_acc    <= '0;
         r_go     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_result <= '0;
      end else begin
         r_go   <= is_div_state(w_state_next) && (w_state_next != r_state);
         r_busy <= (w_state_next != S_IDLE) && (w_state_next != S_REDUCE);
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               r_angle <= angle;
`ifdef TRIG_COS_EN
               r_func  <= func_sel;
`endif
            end
            S_REDUCE: begin
               r_d   <= w_d;
               r_neg <= w_neg;
            end
            S_ERR: begin
               r_result <= '0;
               r_err    <= 1'b1;
               r_done   <= 1'b1;
            end
            S_RAD: if (w_rdy) begin
               r_x   <= w_quotient;
               r_acc <= w_q18;
            end
            S_X2: if (w_rdy) r_x2 <= w_quotient;
            S_T3: if (w_rdy) begin
               r_t   <= w_quotient;
               r_acc <= r_acc - w_q18;
            end
            S_T5: if (w_rdy) begin
               r_t   <= w_quotient;
               r_acc <= r_acc + w_q18;
            end
            S_T7: if (w_rdy) begin
               r_t   <= w_quotient;
               r_acc <= r_acc - w_q18;
            end
            S_T9: if (w_rdy) begin
               r_t   <= w_quotient;
               r_acc <= r_acc + w_q18;
            end
            S_FINAL: begin
               r_result <= r_neg ? 16'(-w_mag) : 16'(w_mag);
               r_err    <= 1'b0;
               r_done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign err    = r_err;
   assign result = r_result;

endmodule

// File: tb/tb_sin_seq_ctrl.sv
// Scoreboard bench for sin_seq_ctrl: stimulus pushes expected responses, a monitor pops on done.
module tb_sin_seq_ctrl;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic [15:0]        angle;
`ifdef TRIG_COS_EN
   logic               func_sel;
`endif
   logic               busy;
   logic               done;
   logic               err;
   logic signed [15:0] result;

   sin_seq_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .angle    (angle),
`ifdef TRIG_COS_EN
      .func_sel (func_sel),
`endif
      .busy     (busy),
      .done     (done),
      .err      (err),
      .result   (result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int ang;
      bit fs;
      int res;
      bit e;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: quadrant fold, then the truncated Taylor series in plain integer arithmetic.
   function automatic void model(input int ang, input bit fs, output int res, output bit e);
      int a, d;
      bit neg;
      longint x, x2, t3, t5, t7, t9, acc;
      if (ang >= 360) begin
         e = 1'b1;
         res = 0;
         return;
      end
      e = 1'b0;
      a = fs ? (ang + 90) % 360 : ang;
      if (a <= 90)       begin d = a;       neg = 1'b0; end
      else if (a <= 180) begin d = 180 - a; neg = 1'b0; end
      else if (a <= 270) begin d = a - 180; neg = 1'b1; end
      else               begin d = 360 - a; neg = 1'b1; end
      x   = longint'(d) * 220000 / 1260;
      x2  = x * x / 10000;
      t3  = x * x2 / 60000;
      t5  = t3 * x2 / 200000;
      t7  = t5 * x2 / 420000;
      t9  = t7 * x2 / 720000;
      acc = x - t3 + t5 - t7 + t9;
      if (acc < 0)     acc = 0;
      if (acc > 10000) acc = 10000;
      res = neg ? -int'(acc) : int'(acc);
   endfunction

   always @(negedge clk) begin
      exp_t ex;
      if (rst_n && done) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 result=%0d expected no pending request (cycle %0d)",
                     result, cyc);
         end else begin
            ex = q.pop_front();
            $display("txn angle=%0d func=%0d result=%0d err=%0d cycle=%0d", ex.ang, ex.fs, result, err, cyc);
            check("result", int'(result), ex.res);
            check("err", int'(err), int'(ex.e));
            check("done_cycle", cyc, ex.cyc);
            check("busy_at_done", int'(busy), 0);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input int a, input bit fs, input int res, input bit e);
      exp_t ex;
      start = 1'b1;
      angle = 16'(a);
`ifdef TRIG_COS_EN
      func_sel = fs;
`endif
      @(negedge clk);
      start    = 1'b0;
      ex.ang = a;
      ex.fs  = fs;
      ex.res = res;
      ex.e   = e;
      ex.cyc = cyc + (e ? 2 : 200);
      q.push_back(ex);
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (i == 0) check("busy_after_accept", int'(busy), 1);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: got no done within 400 cycles expected done (cycle %0d)", cyc);
      end
   endtask

   int tab_a [10] = '{0, 30, 150, 210, 330, 90, 270, 180, 400, 30};
   int tab_r [10] = '{0, 5002, 5002, -5002, -5002, 10000, -10000, 0, 0, 5002};
   bit tab_e [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

   initial begin
      int base, ra, rres;
      bit rfs, re;
      rst_n = 1'b0;
      start = 1'b0;
      angle = '0;
`ifdef TRIG_COS_EN
      func_sel = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_err", int'(err), 0);
      check("reset_result", int'(result), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         issue(tab_a[i], 1'b0, tab_r[i], tab_e[i]);
         wait_done();
         @(negedge clk);
      end

      // Start coinciding with done is accepted; old result held during the new run.
      issue(30, 1'b0, 5002, 1'b0);
      wait_done();
      issue(210, 1'b0, -5002, 1'b0);
      repeat (50) @(negedge clk);
      check("result_held", int'(result), 5002);
      wait_done();
      @(negedge clk);

      // Starts while busy must be ignored.
      issue(30, 1'b0, 5002, 1'b0);
      base = cyc;
      while (cyc < base + 5) @(negedge clk);
      start = 1'b1; angle = 16'd200;
      @(negedge clk);
      start = 1'b0;
      while (cyc < base + 100) @(negedge clk);
      start = 1'b1; angle = 16'd400;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      @(negedge clk);

      // Asynchronous reset mid-run.
      issue(90, 1'b0, 10000, 1'b0);
      base = cyc;
      while (cyc < base + 120) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_err", int'(err), 0);
      check("abort_result", int'(result), 0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         ra = int'($urandom_range(0, 399));
`ifdef TRIG_COS_EN
         rfs = 1'($urandom_range(0, 1));
`else
         rfs = 1'b0;
`endif
         model(ra, rfs, rres, re);
         issue(ra, rfs, rres, re);
         wait_done();
         @(negedge clk);
      end

`ifdef TRIG_COS_EN
      issue(60, 1'b1, 5002, 1'b0);
      wait_done();
      @(negedge clk);
      issue(0, 1'b1, 10000, 1'b0);
      wait_done();
      @(negedge clk);
      issue(300, 1'b1, 5002, 1'b0);
      wait_done();
      @(negedge clk);
`endif

      repeat (5) @(negedge clk);
      check("pending_at_end", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sin_seq_ctrl.md
# sin_seq_ctrl

Sequential controller that evaluates sine of an integer angle in degrees. It uses one shared iterative divider, which replaces the fully combinational Taylor datapath and its cascade of wide constant divisions. The block reduces the angle to the first quadrant, converts it to radians in ×10000 fixed point, and evaluates x − x³/3! + x⁵/5! − x⁷/7! + x⁹/9! term by term. It then applies the quadrant sign. It sits between the calculator's operand/op-select logic and the result display mux.

## Interface
Parameters: none; all constants live in the package.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when busy=0
- angle  in  16  unsigned angle in degrees, valid 0..359
- func_sel  in  1  0=sin, 1=cos (present only with TRIG_COS_EN)
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse; result/err valid from this cycle on
- err  out  1  angle ≥ 360 on last accepted request; held until next accept
- result  out  16  signed sine ×10000, range −10000..10000; held until next accept

## Operation
- Reset values: busy=0, done=0, err=0, result=0, FSM=IDLE, all datapath registers 0.
- Accept: start=1 while busy=0 captures angle (and func_sel). start while busy=1 is ignored with no side effect.
- FSM states:
  - IDLE → REDUCE on accept.
  - REDUCE → ERR if angle ≥ 360, else → RAD.
  - ERR → IDLE: result=0, err=1, done pulse.
  - RAD → X2 → T3 → T5 → T7 → T9 → FINAL → IDLE.
- REDUCE: with d = angle:
  - d ≤ 90: d, sign +.
  - 91..180: 180−d, sign +.
  - 181..270: d−180, sign −.
  - 271..359: 360−d, sign −.
- Division steps. Each state issues one unsigned 32/32 division and truncates the quotient:
  - RAD: x = d·220000 / 1260.
  - X2: x2 = x·x / 10000.
  - Tk (k=3,5,7,9): t = t_prev·x2 / (10000·(k−1)·k), with t_prev = x for T3. Divisors are 60000, 200000, 420000, 720000.
- Accumulator: signed 18 bits, acc = x − t3 + t5 − t7 + t9.
- FINAL: clamp acc to 0..10000, apply sign, write result. A negative zero is written as 0.
- All intermediate products must fit in 32 bits; the maximum is x·x2 ≈ 3.9e8, so no overflow handling is required.
- Reset asserted mid-operation aborts immediately to the reset values. A partially computed result is never output.

## Timing
- Accept edge = cycle 0. busy=1 from cycle 1.
- Each division state lasts exactly 33 cycles: 1 issue cycle plus 32 iterations.
- Valid angle: done=1 and busy=0 in cycle 200 (REDUCE 1 + 6×33 + FINAL 1). result and err update in the same cycle.
- Invalid angle: done=1 in cycle 2.
- A start coinciding with done (busy=0) is accepted. The new run begins, and the old result stays held until the new done.

## Configuration
- TRIG_COS_EN defined:
  - func_sel port exists.
  - With func_sel=1, REDUCE first forms a = angle+90, minus 360 if ≥ 360, using cos θ = sin(θ+90). It then reduces a.
  - The ≥360 check applies to the raw angle.
  - Latency is unchanged.
- TRIG_COS_EN undefined: no func_sel port; the block computes sine only.

## Structure
- Package trig_pkg holds:
  - the FSM state enum;
  - SCALE=10000, RAD_NUM=220000, RAD_DEN=1260;
  - the term divisor constants 60000/200000/420000/720000;
  - DIV_CYCLES=32.
- Sub-module trig_div32 is a restoring unsigned 32/32 divider.
  - Ports: clk, rst_n, go, dividend, divisor, quotient, rdy.
  - Fixed 32-iteration latency; rdy pulses on the last cycle.
  - The controller owns all sequencing.

## Test plan
- Reset, then angle=0 start → done at cycle 200, result=0, err=0.
- angle=30 → result=5002; angle=150 → 5002; angle=210 → −5002; angle=330 → −5002.
- angle=90 → raw acc 10001, clamped result=10000; angle=270 → −10000; angle=180 → 0.
- angle=400 → done at cycle 2, err=1, result=0. A following angle=30 clears err, result=5002.
- start pulsed at cycles 5 and 100 during an angle=30 run → single done at cycle 200, result=5002. rst_n low at cycle 120 → busy=0, result=0 immediately.
- With TRIG_COS_EN: func_sel=1, angle=60 → 5002; angle=0 → 10000; angle=300 → 5002.
